// File: rtl/m_alu_seq.sv
// m_alu_seq: handshaked ALU, iterative mul/div, {V,N,Z,C} flags.
// ALU_SEQ_HI_RESULT_EN drives result_hi with product high / remainder.
module m_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [SW-1:0]    cnt;
  logic             div_r;

  logic is_md;
  logic accept;
  logic last;

  assign is_md  = (op == 4'h2) || (op == 4'h3);
  assign accept = (state == IDLE) && in_valid;
  assign last   = (cnt == SW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = is_md ? BUSY : DONE;
      BUSY: if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // One iteration: mul keeps {hi,lo} = {acc, multiplier};
  // div keeps hi = partial remainder, lo = dividend/quotient.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    mul_sum  = {1'b0, hi_r} + {1'b0, (lo_r[0] ? b_r : '0)};
    div_sh   = {hi_r, lo_r[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, b_r});
    div_diff = div_sh[WIDTH-1:0] - b_r;
    if (div_r) begin
      step_hi = div_ge ? div_diff : div_sh[WIDTH-1:0];
      step_lo = {lo_r[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_r[WIDTH-1:1]};
    end
  end

  logic [SW-1:0]    sh;
  logic [SW:0]      sh_inv;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    sh       = b[SW-1:0];
    sh_inv   = (SW + 1)'(WIDTH) - {1'b0, sh};
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    shl_full = {1'b0, a} << sh;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op)
      4'h0: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                  (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'h1: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                  (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'h4: begin
        alu_res = shl_full[WIDTH-1:0];
        alu_c   = shl_full[WIDTH];
      end
      4'h5: alu_res = a >> sh;
      4'h6: alu_res = a & b;
      4'h7: alu_res = a | b;
      4'h8: alu_res = a ^ b;
      4'h9: alu_res = ~(a ^ b);
      4'hA: alu_res = ~(a & b);
      4'hB: alu_res = ~(a | b);
      // shift by WIDTH yields zero, so amount 0 needs no special case
      4'hC: alu_res = (a << sh) | (a >> sh_inv);
      4'hD: alu_res = (a >> sh) | (a << sh_inv);
      4'hE: alu_res = {{(WIDTH-1){1'b0}}, (a > b)};
      4'hF: alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: alu_res = '0;
    endcase
  end

  logic             ld;
  logic [WIDTH-1:0] nres;
  logic             nc;
  logic             nv;

  always_comb begin
    ld   = 1'b0;
    nres = '0;
    nc   = 1'b0;
    nv   = 1'b0;
    if (accept && !is_md) begin
      ld   = 1'b1;
      nres = alu_res;
      nc   = alu_c;
      nv   = alu_v;
    end else if (state == BUSY && last) begin
      ld   = 1'b1;
      nres = step_lo;
      nc   = !div_r && (step_hi != '0);
      nv   = div_r && (b_r == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_r    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      cnt    <= '0;
      div_r  <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else begin
      if (accept) begin
        b_r   <= b;
        hi_r  <= '0;
        lo_r  <= a;
        cnt   <= '0;
        div_r <= (op == 4'h3);
      end else if (state == BUSY) begin
        hi_r <= step_hi;
        lo_r <= step_lo;
        cnt  <= cnt + 1'b1;
      end
      if (ld) begin
        result <= nres;
        flags  <= {nv, nres[WIDTH-1], (nres == '0), nc};
      end
    end
  end

`ifdef ALU_SEQ_HI_RESULT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      result_hi <= '0;
    end else if (ld) begin
      result_hi <= (state == BUSY) ? step_hi : '0;
    end
  end
`else
  assign result_hi = '0;
`endif

endmodule

// File: tb/tb_m_alu_seq.sv
// tb_m_alu_seq: directed vectors for m_alu_seq (WIDTH=8).
// Expected values are hand-computed constants.
module tb_m_alu_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic [3:0] flags;

  int n_checks = 0;
  int n_fail   = 0;

  m_alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [7:0] v);
`ifdef ALU_SEQ_HI_RESULT_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  task automatic run_op(input string      tag,
                        input logic [3:0] o,
                        input logic [7:0] x,
                        input logic [7:0] y,
                        input int         lat_exp,
                        input logic [7:0] r_exp,
                        input logic [7:0] h_exp,
                        input logic [3:0] f_exp);
    int lat;
    int low;
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    low = in_ready ? 0 : 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      low += in_ready ? 0 : 1;
    end
    check({tag, " latency"}, lat, lat_exp);
    check({tag, " in_ready low"}, low, lat_exp);
    check({tag, " result"}, result, r_exp);
    check({tag, " result_hi"}, result_hi, h_exp);
    check({tag, " flags"}, flags, f_exp);
    @(posedge clk); #1;
    check({tag, " back to idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset result", result, 8'h00);
    check("reset result_hi", result_hi, 8'h00);
    check("reset flags", flags, 4'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add ff+01", 4'h0, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 4'h3);
    run_op("sub 71-06", 4'h1, 8'h71, 8'h06, 1, 8'h6B, 8'h00, 4'h0);
    run_op("sub 01-02", 4'h1, 8'h01, 8'h02, 1, 8'hFF, 8'h00, 4'h5);
    run_op("add ovf", 4'h0, 8'h7F, 8'h01, 1, 8'h80, 8'h00, 4'hC);
    run_op("mul", 4'h2, 8'h10, 8'h20, 9, 8'h00, hx(8'h02), 4'h3);
    run_op("div", 4'h3, 8'h64, 8'h07, 9, 8'h0E, hx(8'h02), 4'h0);
    run_op("div0", 4'h3, 8'h05, 8'h00, 9, 8'hFF, hx(8'h05), 4'hC);
    run_op("shl b9", 4'h4, 8'h81, 8'h09, 1, 8'h02, 8'h00, 4'h1);
    run_op("rol", 4'hC, 8'h81, 8'h01, 1, 8'h03, 8'h00, 4'h0);
    run_op("ror", 4'hD, 8'h81, 8'h01, 1, 8'hC0, 8'h00, 4'h4);
    run_op("nand", 4'hA, 8'hFF, 8'hFF, 1, 8'h00, 8'h00, 4'h2);
    run_op("gt", 4'hE, 8'h05, 8'h03, 1, 8'h01, 8'h00, 4'h0);
    run_op("eq", 4'hF, 8'h07, 8'h07, 1, 8'h01, 8'h00, 4'h0);

    // hold the result under backpressure while a new op is offered
    out_ready = 1'b0;
    op        = 4'h4;
    a         = 8'h71;
    b         = 8'h06;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    op = 4'h0;
    a  = 8'h01;
    b  = 8'h01;
    check("bp out_valid", out_valid, 1'b1);
    check("bp result", result, 8'h40);
    check("bp flags", flags, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp hold result", result, 8'h40);
      check("bp hold flags", flags, 4'h0);
      check("bp hold ready", {out_valid, in_ready}, 2'b10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release", {out_valid, in_ready}, 2'b01);
    check("bp result kept", result, 8'h40);

    op       = 4'h2;
    a        = 8'h10;
    b        = 8'h20;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst mid mul ready", {out_valid, in_ready}, 2'b01);
    check("rst mid mul result", result, 8'h00);
    check("rst mid mul hi", result_hi, 8'h00);
    check("rst mid mul flags", flags, 4'h0);
    repeat (12) @(posedge clk);
    #1;
    check("rst no emit", out_valid, 1'b0);

    run_op("xor", 4'h8, 8'h01, 8'h04, 1, 8'h05, 8'h00, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m_alu_seq.md
Name: m_alu_seq

Overview:
Parametrised, handshaked successor to the 8-bit combinational m_alu. It keeps the same 4-bit opcode map and adds 4-bit flags, WIDTH generalisation, registered outputs and iterative multi-cycle multiply/divide. It sits between an operand-issue stage and a result-consuming stage, using valid/ready on both sides.

Parameters:
WIDTH, 8, operand/result width in bits; power of two, minimum 4.

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands/opcode valid
in_ready  out  1  block can accept an operation
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  4  opcode
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  primary result
result_hi  out  WIDTH  product upper half / division remainder (see Optional Feature)
flags  out  4  {V,N,Z,C} = flags[3:0]

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, result_hi=0, flags=0. Reset takes priority over everything, including aborting an in-flight mul/div; no result is emitted.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid:
  - a, b and op are captured.
  - op 2 or 3 -> BUSY.
  - All other ops -> DONE next cycle, with result computed from the captured values.
- BUSY: in_ready=0. Iterative shift-add multiply or restoring divide, one bit per cycle, WIDTH cycles, then -> DONE.
- DONE: out_valid=1; result, result_hi and flags are held stable until out_ready=1, then -> IDLE. in_ready=0 in DONE, so there is no overlap.
- Latency, accept edge to out_valid:
  - 1 cycle for single-cycle ops.
  - WIDTH+1 cycles for mul/div.
  - Maximum throughput is one op per 2 cycles.
- Opcodes (all results modulo 2^WIDTH):
  - 0 add
  - 1 sub (a-b)
  - 2 mul unsigned (low half)
  - 3 div unsigned (quotient)
  - 4 shl
  - 5 shr logical
  - 6 and
  - 7 or
  - 8 xor
  - 9 xnor
  - A nand
  - B nor
  - C rotate left
  - D rotate right
  - E a>b unsigned (result 1/0)
  - F a==b (result 1/0)
- Shift/rotate amount = b[log2(WIDTH)-1:0]; upper bits of b are ignored.
- Flags:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - C:
    - add: carry-out.
    - sub: borrow (a<b).
    - shl: last bit shifted out (0 if amount 0).
    - mul: upper half nonzero.
    - all other ops: 0.
  - V:
    - add/sub: signed overflow.
    - div: divide-by-zero.
    - all other ops: 0.
- Divide by zero: result = all ones, result_hi = a, V=1; still takes WIDTH+1 cycles.
- in_valid while in_ready=0 is ignored; upstream must hold its operands.
- Results change only on the IDLE->DONE or BUSY->DONE transition.

Optional Feature:
- Macro ALU_SEQ_HI_RESULT_EN.
- Defined: result_hi carries the upper WIDTH bits of the product (op 2) or the remainder (op 3), and is 0 for other ops.
- Undefined: the port remains but is tied to 0, and the upper-half/remainder storage is removed. The mul C flag is still computed.

Test Plan:
- Reset, then add a=8'hFF b=8'h01: out_valid 1 cycle after accept, result=8'h00, flags=4'h3 (Z,C).
- Sub a=8'h71 b=8'h06: result=8'h6B, flags=4'h0. Sub a=8'h01 b=8'h02: result=8'hFF, flags=4'h5 (N,C).
- Mul a=8'h10 b=8'h20: in_ready low 9 cycles, out_valid at accept+9, result=8'h00, flags=4'h3, result_hi=8'h02 (8'h00 without macro).
- Div a=8'h64 b=8'h07: result=8'h0E, result_hi=8'h02. Div a=8'h05 b=8'h00: result=8'hFF, result_hi=8'h05, flags=4'hC.
- Backpressure: shl a=8'h71 b=8'h06 (result=8'h40, C=0) with out_ready low 3 cycles: result/flags stable, in_ready=0, new in_valid ignored. Release -> IDLE next cycle.
- rst asserted at cycle 4 of a mul: next cycle out_valid=0, in_ready=1, outputs 0. A subsequent xor a=8'h01 b=8'h04 gives 8'h05.
